// File: rtl/insn_queue_pkg.sv
// Shared types and width helpers for the multi-lane instruction queue.
package insn_queue_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0] insn;
  } insn_entry_t;

  // Bits needed to hold a count in 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/insn_queue_ram.sv
// Entry storage: multi-port write register array with asynchronous read ports.
module insn_queue_ram #(
  parameter int DEPTH    = 8,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int ENTRY_W  = 64,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS-1:0][IDX_W-1:0]     wr_idx,
  input  logic [WR_PORTS-1:0][ENTRY_W-1:0]   wr_data,
  input  logic [RD_PORTS-1:0][IDX_W-1:0]     rd_idx,
  output logic [RD_PORTS-1:0][ENTRY_W-1:0]   rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write indices of one cycle are always distinct, so port order never matters.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p]) mem[wr_idx[p]] <= wr_data[p];
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    assign rd_data[g] = mem[rd_idx[g]];
  end

endmodule

// File: rtl/insn_queue.sv
// Multi-lane in-order instruction queue between fetch and superscalar dispatch.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int QUEUE_DEPTH    = 8,
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   i_flush,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]       i_enq_count,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]      i_enq_pc,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]      i_enq_insn,
  output logic                                   o_enq_ready,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0]    o_deq_count,
  output logic [DISPATCH_WIDTH*ADDR_WIDTH-1:0]   o_deq_pc,
  output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]   o_deq_insn,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]    i_deq_count,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]       o_count
);

  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int EW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int ECW = cnt_w(FETCH_WIDTH);
  localparam int DCW = cnt_w(DISPATCH_WIDTH);
  localparam int OCW = cnt_w(QUEUE_DEPTH);

  logic [PW-1:0]  head, tail;
  logic [OCW-1:0] count;
  logic           enq_ready;
  logic [DCW-1:0] deq_avail, deq_eff;
  logic [ECW-1:0] enq_eff;

  logic [FETCH_WIDTH-1:0]                   wr_en;
  logic [FETCH_WIDTH-1:0][PW-1:0]           wr_idx;
  logic [FETCH_WIDTH-1:0][EW-1:0]           wr_data;
  logic [DISPATCH_WIDTH-1:0][PW-1:0]        rd_idx;
  logic [DISPATCH_WIDTH-1:0][EW-1:0]        rd_data;

  // Readiness and presented count come only from registered state.
  assign enq_ready = count <= OCW'(QUEUE_DEPTH - FETCH_WIDTH);
  assign deq_avail = (count >= OCW'(DISPATCH_WIDTH)) ? DCW'(DISPATCH_WIDTH) : DCW'(count);

  always_comb begin
    enq_eff = '0;
    deq_eff = '0;
    if (!i_flush) begin
      if (enq_ready)
        enq_eff = (i_enq_count > ECW'(FETCH_WIDTH)) ? ECW'(FETCH_WIDTH) : i_enq_count;
      deq_eff = (i_deq_count > deq_avail) ? deq_avail : i_deq_count;
    end
  end

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_wr
    assign wr_en[g]   = ECW'(g) < enq_eff;
    assign wr_idx[g]  = tail + PW'(g);
    assign wr_data[g] = {i_enq_pc[g*ADDR_WIDTH +: ADDR_WIDTH], i_enq_insn[g*DATA_WIDTH +: DATA_WIDTH]};
  end

  for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_rd
    logic lane_on;
    assign lane_on   = DCW'(g) < deq_avail;
    assign rd_idx[g] = head + PW'(g);
    assign o_deq_pc[g*ADDR_WIDTH +: ADDR_WIDTH]   = lane_on ? rd_data[g][EW-1 -: ADDR_WIDTH] : '0;
    assign o_deq_insn[g*DATA_WIDTH +: DATA_WIDTH] = lane_on ? rd_data[g][DATA_WIDTH-1:0] : '0;
  end

  insn_queue_ram #(
    .DEPTH    (QUEUE_DEPTH),
    .WR_PORTS (FETCH_WIDTH),
    .RD_PORTS (DISPATCH_WIDTH),
    .ENTRY_W  (EW),
    .IDX_W    (PW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_eff);
      tail  <= tail + PW'(enq_eff);
      count <= count + OCW'(enq_eff) - OCW'(deq_eff);
    end
  end

  assign o_enq_ready = enq_ready;
  assign o_deq_count = deq_avail;
  assign o_count     = count;

endmodule

// File: tb/tb_insn_queue.sv
// Directed checks of the instruction queue with hand-computed expectations.
module tb_insn_queue;
  import insn_queue_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_flush;
  logic [1:0]  i_enq_count;
  logic [63:0] i_enq_pc;
  logic [63:0] i_enq_insn;
  logic        o_enq_ready;
  logic [1:0]  o_deq_count;
  logic [63:0] o_deq_pc;
  logic [63:0] o_deq_insn;
  logic [1:0]  i_deq_count;
  logic [3:0]  o_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  insn_queue dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_flush     (i_flush),
    .i_enq_count (i_enq_count),
    .i_enq_pc    (i_enq_pc),
    .i_enq_insn  (i_enq_insn),
    .o_enq_ready (o_enq_ready),
    .o_deq_count (o_deq_count),
    .o_deq_pc    (o_deq_pc),
    .o_deq_insn  (o_deq_insn),
    .i_deq_count (i_deq_count),
    .o_count     (o_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic drive(input int ne, input int nd, input logic fl, input insn_entry_t e0, input insn_entry_t e1);
    i_enq_count = 2'(ne);
    i_deq_count = 2'(nd);
    i_flush     = fl;
    i_enq_pc    = {e1.pc, e0.pc};
    i_enq_insn  = {e1.insn, e0.insn};
    @(posedge clk);
    #1;
    i_enq_count = '0;
    i_deq_count = '0;
    i_flush     = 1'b0;
  endtask

  task automatic cyc(input int ne, input int nd, input logic [31:0] p0, input logic [31:0] p1);
    insn_entry_t e0, e1;
    e0.pc = p0; e0.insn = insn_of(p0);
    e1.pc = p1; e1.insn = insn_of(p1);
    drive(ne, nd, 1'b0, e0, e1);
  endtask

  task automatic chk_state(input string tag, input int cnt, input int dc, input logic rdy,
                           input logic [31:0] p0, input logic [31:0] p1);
    chk({tag, ".count"}, 64'(o_count), 64'(cnt));
    chk({tag, ".deq_count"}, 64'(o_deq_count), 64'(dc));
    chk({tag, ".ready"}, 64'(o_enq_ready), 64'(rdy));
    chk({tag, ".pc0"}, 64'(o_deq_pc[31:0]), 64'(p0));
    chk({tag, ".pc1"}, 64'(o_deq_pc[63:32]), 64'(p1));
  endtask

  initial begin
    insn_entry_t e0, e1;
    n_rst = 1'b0; i_flush = 1'b0; i_enq_count = '0; i_deq_count = '0;
    i_enq_pc = '0; i_enq_insn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 1'b1, 32'h0, 32'h0);
    chk("reset.insn", o_deq_insn, 64'h0);
    n_rst = 1'b1;

    // First pair visible one cycle after enqueue.
    e0.pc = 32'h0; e0.insn = 32'h13;
    e1.pc = 32'h4; e1.insn = 32'h93;
    drive(2, 0, 1'b0, e0, e1);
    chk_state("first", 2, 2, 1'b1, 32'h0, 32'h4);
    chk("first.insn0", 64'(o_deq_insn[31:0]), 64'h13);
    chk("first.insn1", 64'(o_deq_insn[63:32]), 64'h93);

    // Fill to depth 8; ready drops and further enqueues are ignored.
    cyc(2, 0, 32'h8, 32'hc);
    cyc(2, 0, 32'h10, 32'h14);
    chk_state("cnt6", 6, 2, 1'b1, 32'h0, 32'h4);
    cyc(2, 0, 32'h18, 32'h1c);
    chk_state("full", 8, 2, 1'b0, 32'h0, 32'h4);
    cyc(2, 0, 32'h100, 32'h104);
    chk_state("full_ign", 8, 2, 1'b0, 32'h0, 32'h4);
    chk("full_ign.insn0", 64'(o_deq_insn[31:0]), 64'h13);

    // Drain one per cycle while fetch keeps offering a pair.
    cyc(2, 1, 32'h20, 32'h24);
    chk_state("d1", 7, 2, 1'b0, 32'h4, 32'h8);
    cyc(2, 1, 32'h20, 32'h24);
    chk_state("d2", 6, 2, 1'b1, 32'h8, 32'hc);
    cyc(2, 1, 32'h20, 32'h24);  // accepted: tail wraps 0 -> 2
    chk_state("d3", 7, 2, 1'b0, 32'hc, 32'h10);
    cyc(0, 2, 32'h0, 32'h0);
    chk_state("d4", 5, 2, 1'b1, 32'h14, 32'h18);
    cyc(0, 2, 32'h0, 32'h0);
    chk_state("wrap", 3, 2, 1'b1, 32'h1c, 32'h20);
    chk("wrap.insn1", 64'(o_deq_insn[63:32]), 64'(insn_of(32'h20)));

    // Count 3, simultaneous enqueue 2 / dequeue 2.
    cyc(2, 2, 32'h28, 32'h2c);
    chk_state("simul", 3, 2, 1'b1, 32'h24, 32'h28);
    cyc(0, 2, 32'h0, 32'h0);
    chk_state("one", 1, 1, 1'b1, 32'h2c, 32'h0);
    chk("one.insn1", 64'(o_deq_insn[63:32]), 64'h0);
    cyc(0, 2, 32'h0, 32'h0);
    chk_state("clamp_deq", 0, 0, 1'b1, 32'h0, 32'h0);
    cyc(0, 2, 32'h0, 32'h0);
    chk_state("empty_deq", 0, 0, 1'b1, 32'h0, 32'h0);

    // Enqueue count above FETCH_WIDTH clamps to 2.
    cyc(3, 0, 32'h40, 32'h44);
    chk_state("clamp_enq", 2, 2, 1'b1, 32'h40, 32'h44);
    cyc(2, 0, 32'h48, 32'h4c);
    cyc(1, 0, 32'h50, 32'h0);
    chk_state("cnt5", 5, 2, 1'b1, 32'h40, 32'h44);

    // Flush discards same-cycle enq/deq; next enqueue lands at index 0.
    e0.pc = 32'h58; e0.insn = insn_of(32'h58);
    e1.pc = 32'h5c; e1.insn = insn_of(32'h5c);
    drive(2, 2, 1'b1, e0, e1);
    chk_state("flush", 0, 0, 1'b1, 32'h0, 32'h0);
    cyc(1, 0, 32'h60, 32'h0);
    chk_state("post_flush", 1, 1, 1'b1, 32'h60, 32'h0);
    chk("post_flush.insn0", 64'(o_deq_insn[31:0]), 64'(insn_of(32'h60)));

    // Asynchronous reset mid-cycle clears outputs immediately.
    cyc(2, 0, 32'h64, 32'h68);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 1'b1, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc(1, 0, 32'h70, 32'h0);
    chk_state("after_rst", 1, 1, 1'b1, 32'h70, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
